gather_sum_accum: RTL and testbench
===================================

# gather_sum_accum

Downstream consumer of the gathered-operand stage. Each cycle it takes one gathered vector (num_in_p lanes of width_p signed values), sums the lanes in a registered stage, and accumulates the lane sums over a programmable number of beats. It then presents the signed group total on a valid/ready output. It feeds the cycle-accurate simulator's reduction path (dot-product partials) with one result per group.

## Interface
- width_p, default 16: lane width, signed two's complement.
- num_in_p, default 4: lanes per gathered vector; must be at least 1.
- count_width_p, default 8: width of the beat-count config.
- acc_width_p, default width_p + `BSG_SAFE_CLOG2(num_in_p) + count_width_p: result width; covers the worst case without overflow.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_n_i  in  1  asynchronous active-low reset. Assertion is asynchronous; deassertion is synchronised externally.
- cfg_len_i  in  count_width_p  beats per group, sampled on the group's first accepted beat. 0 is treated as 1.
- v_i  in  1  gathered vector valid.
- data_i  in  [num_in_p][width_p]  gathered lanes.
- yumi_o  out  1  consume strobe to the gather stage. Combinational; asserted only when v_i=1.
- v_o  out  1  group result valid.
- data_o  out  acc_width_p  signed group total.
- ready_i  in  1  downstream ready.

## Operation
- States: IDLE, ACC, WAIT, HOLD. Reset state is IDLE.
- yumi_o = reset_n_i & v_i & ((state==IDLE) | (state==ACC & cnt_r != len_r)).
- IDLE, beat accepted:
  - len_r <= (cfg_len_i==0 ? 1 : cfg_len_i); cnt_r <= 1.
  - If len_r resolves to 1: go to WAIT. Otherwise go to ACC.
- ACC, beat accepted: cnt_r++. When the incremented cnt_r equals len_r, go to WAIT.
- cfg_len_i is ignored outside the first beat of a group.
- Stage 1, on every accepted beat:
  - s1_sum_r <= sign-extended sum of all lanes, computed at acc_width_p.
  - s1_v_r <= 1; s1_first_r <= (beat is first of group); s1_last_r <= (beat is last of group).
  - On any cycle with no accepted beat, s1_v_r <= 0.
- Accumulate, when s1_v_r=1:
  - acc_r <= (s1_first_r ? 0 : acc_r) + s1_sum_r.
  - If s1_last_r=1, state goes to HOLD and v_o is set.
- data_o = acc_r. Stable while v_o=1.
- HOLD: yumi_o=0. On v_o & ready_i, v_o <= 0 and state goes to IDLE.
- No overflow is possible: the total of 2^count_width_p − 1 beats × num_in_p lanes × −2^(width_p−1) fits in acc_width_p.
- Reset, async low:
  - state=IDLE; cnt_r=0, len_r=0, s1_v_r=0, acc_r=0, v_o=0, data_o=0; yumi_o=0 while reset_n_i=0.
  - A partially accumulated group is discarded. The first beat accepted after reset starts a new group.

## Timing
- Last beat accepted in cycle t: s1 valid in t+1, v_o=1 from t+2.
- Throughput per group is len + 2 cycles plus backpressure cycles. Beats stream back-to-back at one per cycle inside a group.
- Handshake completes in cycle h (v_o & ready_i). The state is IDLE in h+1, and yumi_o may assert in h+1.
- No beat is accepted in WAIT or HOLD, or in ACC after len beats.
- v_o and data_o are registered. yumi_o is the only combinational output.
- No input-to-output combinational path exists except v_i → yumi_o.

## Test plan
- len=1, lanes {1,2,3,4}, ready_i=1 → yumi_o for one cycle, then v_o=1 two cycles later with data_o=10, then v_o=0 and IDLE.
- len=3, three back-to-back beats of all lanes = 1 → yumi_o high for 3 consecutive cycles, then low. data_o=12, v_o rises 2 cycles after the third beat.
- Signed extreme, len=255, every lane = −32768 → data_o = −33423360 (26-bit); no wrap.
- Backpressure: hold ready_i=0 for 5 cycles after v_o rises, with v_i=1 throughout.
  - v_o, data_o stable and yumi_o=0 for all 5 cycles.
  - Raise ready_i → IDLE next cycle; the next group's first beat is accepted in that cycle.
- Config handling: cfg_len_i=0 → the group closes after 1 beat. Changing cfg_len_i from 2 to 5 after the first beat → the group still closes after 2 beats.
- Assert reset_n_i low mid-ACC (after 2 of 4 beats) → v_o=0 and yumi_o=0 immediately. After release, a len=1 group {5,5,5,5} gives data_o=20, with no stale partial sum.

Source files
------------

// File: rtl/gather_sum_accum.sv
// Lane-sum and group accumulator for gathered operand vectors: one stage sums the lanes,
// the next accumulates the lane sums over cfg_len_i beats, and the total is held on valid/ready.

module gather_sum_lane_ext #(
    parameter int width_p     = 16,
    parameter int acc_width_p = 26
) (
    input  logic [width_p-1:0]            lane_i,
    output logic signed [acc_width_p-1:0] ext_o
);
    assign ext_o = {{(acc_width_p-width_p){lane_i[width_p-1]}}, lane_i};
endmodule

module gather_sum_accum #(
    parameter int width_p       = 16,
    parameter int num_in_p      = 4,
    parameter int count_width_p = 8,
    parameter int acc_width_p   = width_p + ((num_in_p > 1) ? $clog2(num_in_p) : 1) + count_width_p
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic [count_width_p-1:0]             cfg_len_i,
    input  logic                                 v_i,
    input  logic [num_in_p-1:0][width_p-1:0]     data_i,
    output logic                                 yumi_o,
    output logic                                 v_o,
    output logic signed [acc_width_p-1:0]        data_o,
    input  logic                                 ready_i
);
    typedef enum logic [1:0] {IDLE, ACC, WAIT, HOLD} state_e;

    state_e                        state_q, state_d;
    logic [count_width_p-1:0]      cnt_q, cnt_d, len_q, len_d, len_res, cnt_inc;
    logic                          s1_v_q, s1_v_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
    logic signed [acc_width_p-1:0] s1_sum_q, s1_sum_d, acc_q, acc_d;
    logic                          v_o_q, v_o_d;
    logic                          accept, first_beat, last_beat;

    logic [num_in_p-1:0][acc_width_p-1:0] lane_ext;
    logic signed [acc_width_p-1:0]        lane_sum;

    for (genvar g = 0; g < num_in_p; g++) begin : g_lane
        gather_sum_lane_ext #(.width_p(width_p), .acc_width_p(acc_width_p)) u_ext (
            .lane_i (data_i[g]),
            .ext_o  (lane_ext[g])
        );
    end

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < num_in_p; i++) lane_sum = lane_sum + $signed(lane_ext[i]);
    end

    // A zero length is promoted to one so every group closes.
    assign len_res    = (cfg_len_i == '0) ? count_width_p'(1) : cfg_len_i;
    assign cnt_inc    = cnt_q + count_width_p'(1);
    assign first_beat = (state_q == IDLE);
    assign last_beat  = first_beat ? (len_res == count_width_p'(1)) : (cnt_inc == len_q);
    assign accept     = yumi_o;

    // FSM: state register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = last_beat ? WAIT : ACC;
            ACC:     if (accept && last_beat) state_d = WAIT;
            WAIT:    if (s1_v_q && s1_last_q) state_d = HOLD;
            HOLD:    if (v_o_q && ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        yumi_o = 1'b0;
        if (reset_n_i && v_i)
            yumi_o = (state_q == IDLE) || ((state_q == ACC) && (cnt_q != len_q));
    end

    always_comb begin
        cnt_d      = cnt_q;
        len_d      = len_q;
        s1_v_d     = accept;
        s1_first_d = s1_first_q;
        s1_last_d  = s1_last_q;
        s1_sum_d   = s1_sum_q;
        acc_d      = acc_q;
        v_o_d      = v_o_q;
        if (accept) begin
            s1_sum_d   = lane_sum;
            s1_first_d = first_beat;
            s1_last_d  = last_beat;
            if (first_beat) begin
                len_d = len_res;
                cnt_d = count_width_p'(1);
            end else begin
                cnt_d = cnt_inc;
            end
        end
        if (s1_v_q) acc_d = (s1_first_q ? '0 : acc_q) + s1_sum_q;
        if (s1_v_q && s1_last_q)     v_o_d = 1'b1;
        else if (v_o_q && ready_i)   v_o_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q      <= '0;
            len_q      <= '0;
            s1_v_q     <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_sum_q   <= '0;
            acc_q      <= '0;
            v_o_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            s1_v_q     <= s1_v_d;
            s1_first_q <= s1_first_d;
            s1_last_q  <= s1_last_d;
            s1_sum_q   <= s1_sum_d;
            acc_q      <= acc_d;
            v_o_q      <= v_o_d;
        end
    end

    assign v_o    = v_o_q;
    assign data_o = acc_q;
endmodule

// File: tb/tb_gather_sum_accum.sv
// Directed bench for gather_sum_accum: stimulus pushes hand-computed group totals into a
// scoreboard; a monitor pops and compares on every output handshake.

module tb_gather_sum_accum;
    typedef logic [3:0][15:0] lanes_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [7:0]         cfg_len;
    logic               v_i;
    lanes_t             data_i;
    logic               yumi_o;
    logic               v_o;
    logic signed [25:0] data_o;
    logic               ready_i;

    int passed = 0;
    int total  = 0;
    longint sb[$];

    gather_sum_accum dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .cfg_len_i (cfg_len),
        .v_i       (v_i),
        .data_i    (data_i),
        .yumi_o    (yumi_o),
        .v_o       (v_o),
        .data_o    (data_o),
        .ready_i   (ready_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // Drives v_i for ncyc cycles; after the first accepted beat switches to d1/c1.
    task automatic stream(input lanes_t d0, input lanes_t d1, input logic [7:0] c0,
                          input logic [7:0] c1, input int ncyc,
                          output int nacc, output logic [31:0] mask);
        nacc = 0; mask = '0;
        v_i = 1'b1; data_i = d0; cfg_len = c0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (yumi_o) begin
                nacc++;
                if (i < 32) mask[i] = 1'b1;
            end
            @(posedge clk); #1;
            if (nacc > 0) begin data_i = d1; cfg_len = c1; end
        end
        v_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n && v_o && ready_i) begin
                if (sb.size() == 0) check("sb_unexpected_result", 1, 0);
                else check("group_total", longint'(data_o), sb.pop_front());
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        logic [31:0] m;
        lanes_t a, b, c;
        rst_n = 1'b0; v_i = 1'b1; ready_i = 1'b1; cfg_len = 8'd1;
        data_i = {16'd4, 16'd3, 16'd2, 16'd1};
        #12;
        check("reset_yumi", yumi_o, 0);
        check("reset_v_o", v_o, 0);
        check("reset_data_o", data_o, 0);
        @(negedge clk); rst_n = 1'b1; v_i = 1'b0;
        idle(2);

        // len=1, {1,2,3,4}: v_o exactly two cycles after the beat
        sb.push_back(10);
        a = {16'd4, 16'd3, 16'd2, 16'd1};
        stream(a, a, 8'd1, 8'd1, 1, n, m);
        check("len1_beats", n, 1);
        @(negedge clk); check("len1_v_o_t1", v_o, 0);
        @(negedge clk); check("len1_v_o_t2", v_o, 1);
        @(negedge clk); check("len1_v_o_t3", v_o, 0);
        idle(2);

        // len=3, all ones, v_i held: yumi on exactly the first three cycles
        sb.push_back(12);
        a = {16'd1, 16'd1, 16'd1, 16'd1};
        stream(a, a, 8'd3, 8'd3, 5, n, m);
        check("len3_yumi_mask", longint'(m), 7);
        idle(4);

        // signed extreme: 255 beats of four -32768 lanes
        sb.push_back(-33423360);
        a = {16'h8000, 16'h8000, 16'h8000, 16'h8000};
        stream(a, a, 8'd255, 8'd255, 257, n, m);
        check("extreme_beats", n, 255);
        idle(4);

        // backpressure: group {10,-3,7,0}+{1,1,1,1}=18, then next group {5,5,5,5}=20
        sb.push_back(18); sb.push_back(20);
        a = {16'd0, 16'd7, 16'hFFFD, 16'd10};
        b = {16'd1, 16'd1, 16'd1, 16'd1};
        c = {16'd5, 16'd5, 16'd5, 16'd5};
        ready_i = 1'b0; v_i = 1'b1; data_i = a; cfg_len = 8'd2;
        @(negedge clk); check("bp_beat0", yumi_o, 1);
        @(posedge clk); #1; data_i = b;
        @(negedge clk); check("bp_beat1", yumi_o, 1);
        @(posedge clk); #1; data_i = c; cfg_len = 8'd1;
        @(negedge clk); check("bp_wait_yumi", yumi_o, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_v_o", v_o, 1);
            check("bp_hold_data", longint'(data_o), 18);
            check("bp_hold_yumi", yumi_o, 0);
            @(posedge clk); #1;
        end
        ready_i = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); check("bp_next_first_beat", yumi_o, 1);
        @(posedge clk); #1; v_i = 1'b0;
        idle(4);

        // cfg 0 behaves as 1
        sb.push_back(8);
        a = {16'd2, 16'd2, 16'd2, 16'd2};
        stream(a, a, 8'd0, 8'd0, 3, n, m);
        check("cfg0_beats", n, 1);
        idle(4);

        // cfg changed 2->5 after the first beat: still closes after 2 beats, 10+4=14
        sb.push_back(14);
        a = {16'd4, 16'd3, 16'd2, 16'd1};
        b = {16'd1, 16'd1, 16'd1, 16'd1};
        stream(a, b, 8'd2, 8'd5, 4, n, m);
        check("cfg_change_mask", longint'(m), 3);
        idle(4);

        // reset mid-ACC after 2 of 4 beats, then a clean len=1 group
        a = {16'd9, 16'd9, 16'd9, 16'd9};
        stream(a, a, 8'd4, 8'd4, 2, n, m);
        check("rst_partial_beats", n, 2);
        v_i = 1'b1; data_i = {16'd5, 16'd5, 16'd5, 16'd5}; cfg_len = 8'd1;
        #1; check("acc_yumi_before_rst", yumi_o, 1);
        rst_n = 1'b0;
        #1;
        check("rst_yumi", yumi_o, 0);
        check("rst_v_o", v_o, 0);
        check("rst_data_o", data_o, 0);
        sb.push_back(20);
        @(negedge clk); rst_n = 1'b1;
        #1; check("post_rst_yumi", yumi_o, 1);
        @(posedge clk); #1; v_i = 1'b0;
        idle(5);

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
